// File: rtl/systolic_pkg.sv
// systolic_pkg: shared sizes, FSM encoding and diagonal-skew helper for the systolic feeder
package systolic_pkg;

    localparam int N_DEF  = 6;
    localparam int K_DEF  = 6;
    localparam int DW_DEF = 32;

    typedef enum logic [1:0] {LOAD, CLR, RUN, DONE} state_t;

    // K is at most 64, so a 6-bit index always reaches every stored element
    typedef struct packed {
        logic       ok;
        logic [5:0] idx;
    } skew_t;

    // Lane `lane` sees element t-lane at run time t; ok is low outside the K-wide window
    function automatic skew_t skew_idx(input int t, input int lane, input int k);
        skew_t s;
        int    d;
        d     = t - lane;
        s.ok  = (d >= 0) && (d < k);
        s.idx = 6'(d);
        return s;
    endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// systolic_feeder_if: host load stream, array feed buses and result handshake
interface systolic_feeder_if
    import systolic_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int DW = DW_DEF
);
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic [N*DW-1:0] a_out;
    logic [N*DW-1:0] b_out;
    logic            array_clr;
    logic            busy;
    logic            res_valid;
    logic            res_ack;

    modport master (
        input  in_valid, in_data, res_ack,
        output in_ready, a_out, b_out, array_clr, busy, res_valid
    );

    modport slave (
        output in_valid, in_data, res_ack,
        input  in_ready, a_out, b_out, array_clr, busy, res_valid
    );
endinterface

// File: rtl/systolic_feed_lane.sv
// systolic_feed_lane: one row or column feed; emits its stored element in its skewed slot, else zero
module systolic_feed_lane
    import systolic_pkg::*;
#(
    parameter int K    = K_DEF,
    parameter int DW   = DW_DEF,
    parameter int TW   = 4,
    parameter int LANE = 0
) (
    input  logic          en,
    input  logic [TW-1:0] t,
    input  logic [DW-1:0] elems [K],
    output logic [DW-1:0] data
);
    skew_t s;

    // Select the element due at time t; out-of-window lanes stay exactly zero
    always_comb begin
        s    = skew_idx(int'(t), LANE, K);
        data = '0;
        for (int k = 0; k < K; k++) begin
            if (en && s.ok && s.idx == 6'(k)) data = elems[k];
        end
    end
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers A (NxK) and B (KxN), then streams them skewed into an NxN systolic array.
// Optional SYSTOLIC_FEEDER_PERF_EN adds perf_cycles (first load beat to DONE entry, saturating).
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int K  = K_DEF,
    parameter int DW = DW_DEF
) (
    input logic clk,
    input logic rst,
    systolic_feeder_if.master bus
`ifdef SYSTOLIC_FEEDER_PERF_EN
    ,
    output logic [31:0] perf_cycles
`endif
);
    localparam int NK  = N * K;
    localparam int TOT = 2 * NK;
    localparam int T   = K + 2 * N - 2;
    localparam int CW  = $clog2(TOT + 1);
    localparam int MW  = $clog2(TOT);
    localparam int TW  = $clog2(K + 2 * N);

    state_t        state_q, state_d;
    logic [CW-1:0] ld_cnt_q, ld_cnt_d;
    logic [TW-1:0] t_q, t_d;
    logic          clr_hold_q, clr_hold_d;
    logic [DW-1:0] mem_q [TOT];
    logic          accept;
    logic          feed_en;

    assign accept = bus.in_valid && !rst && state_q == LOAD;

    // Control state; reset discards any partial load and re-arms the array clear
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LOAD;
            ld_cnt_q   <= '0;
            t_q        <= '0;
            clr_hold_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            ld_cnt_q   <= ld_cnt_d;
            t_q        <= t_d;
            clr_hold_q <= clr_hold_d;
        end
    end

    // Operand storage: A row-major at 0..NK-1, B column-major at NK..2NK-1, so each lane is contiguous
    always_ff @(posedge clk) begin
        if (accept) mem_q[ld_cnt_q[MW-1:0]] <= bus.in_data;
    end

    // Next-state sequencing and handshake/status outputs
    always_comb begin
        state_d       = state_q;
        ld_cnt_d      = ld_cnt_q;
        t_d           = t_q;
        clr_hold_d    = clr_hold_q;
        bus.in_ready  = !rst && state_q == LOAD;
        bus.busy      = !rst && (state_q == CLR || state_q == RUN);
        bus.res_valid = !rst && state_q == DONE;
        bus.array_clr = rst || clr_hold_q || state_q == CLR;
        feed_en       = !rst && state_q == RUN;
        case (state_q)
            LOAD: begin
                if (accept) begin
                    ld_cnt_d = ld_cnt_q + CW'(1);
                    if (ld_cnt_q == CW'(TOT - 1)) begin
                        state_d  = CLR;
                        ld_cnt_d = '0;
                    end
                end
            end
            CLR: begin
                state_d    = RUN;
                t_d        = '0;
                clr_hold_d = 1'b0;
            end
            RUN: begin
                t_d = t_q + TW'(1);
                if (t_q == TW'(T - 1)) begin
                    state_d = DONE;
                    t_d     = '0;
                end
            end
            DONE: begin
                if (bus.res_ack) state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DW-1:0] row [K];
        logic [DW-1:0] col [K];
        logic [DW-1:0] a_lane;
        logic [DW-1:0] b_lane;
        for (genvar k = 0; k < K; k++) begin : g_elem
            assign row[k] = mem_q[i * K + k];
            assign col[k] = mem_q[NK + i * K + k];
        end
        systolic_feed_lane #(.K(K), .DW(DW), .TW(TW), .LANE(i)) u_row (
            .en   (feed_en),
            .t    (t_q),
            .elems(row),
            .data (a_lane)
        );
        systolic_feed_lane #(.K(K), .DW(DW), .TW(TW), .LANE(i)) u_col (
            .en   (feed_en),
            .t    (t_q),
            .elems(col),
            .data (b_lane)
        );
        assign bus.a_out[i*DW +: DW] = a_lane;
        assign bus.b_out[i*DW +: DW] = b_lane;
    end

`ifdef SYSTOLIC_FEEDER_PERF_EN
    logic [31:0] perf_cnt_q, perf_cnt_d, perf_q, perf_d, perf_inc;

    // Running cycle count starts on the first accepted beat; latched as the FSM enters DONE
    always_comb begin
        perf_inc   = (perf_cnt_q == '1) ? perf_cnt_q : perf_cnt_q + 32'd1;
        perf_cnt_d = perf_cnt_q;
        perf_d     = perf_q;
        case (state_q)
            LOAD: perf_cnt_d = (accept && ld_cnt_q == '0) ? 32'd1 : (ld_cnt_q != '0) ? perf_inc : perf_cnt_q;
            CLR:  perf_cnt_d = perf_inc;
            RUN: begin
                perf_cnt_d = perf_inc;
                perf_d     = (t_q == TW'(T - 1)) ? perf_inc : perf_q;
            end
            default: perf_cnt_d = perf_cnt_q;
        endcase
    end

    // Performance counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cnt_q <= '0;
            perf_q     <= '0;
        end else begin
            perf_cnt_q <= perf_cnt_d;
            perf_q     <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`endif
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: randomized load/run/ack scenarios checked against a matrix-level reference model
module tb_systolic_feeder;
    localparam int N   = 6;
    localparam int K   = 6;
    localparam int DW  = 32;
    localparam int TOT = 2 * N * K;
    localparam int T   = K + 2 * N - 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    systolic_feeder_if #(.N(N), .DW(DW)) bus ();
`ifdef SYSTOLIC_FEEDER_PERF_EN
    logic [31:0] perf_cycles;
`endif

    systolic_feeder #(.N(N), .K(K), .DW(DW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
`ifdef SYSTOLIC_FEEDER_PERF_EN
        ,
        .perf_cycles(perf_cycles)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int first_cyc = 0;
    int extra_hs = 0;

    logic [DW-1:0]   A  [N][K];
    logic [DW-1:0]   B  [K][N];
    logic [N*DW-1:0] ah [T];
    logic [N*DW-1:0] bh [T];

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [N*DW-1:0] got, input logic [N*DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N*DW-1:0] exp_a(input int t);
        logic [N*DW-1:0] v = '0;
        for (int i = 0; i < N; i++) if (t - i >= 0 && t - i < K) v[i*DW +: DW] = A[i][t-i];
        return v;
    endfunction

    function automatic logic [N*DW-1:0] exp_b(input int t);
        logic [N*DW-1:0] v = '0;
        for (int j = 0; j < N; j++) if (t - j >= 0 && t - j < K) v[j*DW +: DW] = B[t-j][j];
        return v;
    endfunction

    function automatic logic [DW-1:0] beat(input int idx);
        return (idx < N * K) ? A[idx / K][idx % K] : B[(idx - N * K) % K][(idx - N * K) / K];
    endfunction

    function automatic logic [3:0] status();
        return {bus.array_clr, bus.busy, bus.res_valid, bus.in_ready};
    endfunction

    task automatic rand_mats();
        for (int i = 0; i < N; i++) for (int k = 0; k < K; k++) A[i][k] = $urandom;
        for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) B[k][j] = $urandom;
    endtask

    task automatic do_load(input int gap);
        int   idx = 0;
        int   guard = 0;
        logic hs;
        while (idx < TOT && guard < 5000) begin
            bus.in_valid = ($urandom_range(99) >= gap);
            bus.in_data  = beat(idx);
            hs = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            guard++;
            if (hs) begin
                if (idx == 0) first_cyc = cyc;
                idx++;
            end
        end
        check("load_beats", idx, TOT);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hdeadbeef;
    endtask

    task automatic do_run(input int mode, input int hold, input int rst_at);
        logic [DW-1:0] c;
        logic [DW-1:0] p;
        extra_hs = 0;
        check("clr_status", status(), 4'b1100);
        check("clr_feeds", bus.a_out | bus.b_out, 0);
        for (int t = 0; t < T; t++) begin
            extra_hs += int'(bus.in_valid && bus.in_ready);
            bus.res_ack = 1'($urandom_range(1));
            @(posedge clk); #1;
            check($sformatf("run_a_t%0d", t), bus.a_out, exp_a(t));
            check($sformatf("run_b_t%0d", t), bus.b_out, exp_b(t));
            check($sformatf("run_status_t%0d", t), status(), 4'b0100);
            ah[t] = bus.a_out;
            bh[t] = bus.b_out;
            if (mode == 1 && t == 5) begin
                check("skew_a0", bus.a_out[0 +: DW], 6);
                check("skew_a5", bus.a_out[5*DW +: DW], 81);
                check("skew_b5", bus.b_out[5*DW +: DW], 1);
            end
            if (t == rst_at) begin
                bus.in_valid = 1'b0;
                bus.res_ack  = 1'b0;
                rst = 1'b1;
                @(posedge clk); #1;
                check("midrun_rst_status", status(), 4'b1000);
                check("midrun_rst_feeds", bus.a_out | bus.b_out, 0);
                rst = 1'b0;
                @(posedge clk); #1;
                check("midrun_rst_load", status(), 4'b1001);
                return;
            end
        end
        extra_hs += int'(bus.in_valid && bus.in_ready);
        bus.res_ack = 1'($urandom_range(1));
        @(posedge clk); #1;
        bus.res_ack  = 1'b0;
        bus.in_valid = 1'b0;
        check("done_status", status(), 4'b0010);
        check("done_feeds", bus.a_out | bus.b_out, 0);
`ifdef SYSTOLIC_FEEDER_PERF_EN
        check("perf_cycles", perf_cycles, cyc - first_cyc + 1);
`endif
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                c = '0;
                p = '0;
                for (int t = 0; t < T; t++)
                    if (t - j >= 0 && t - i >= 0) c += ah[t-j][i*DW +: DW] * bh[t-i][j*DW +: DW];
                for (int k = 0; k < K; k++) p += A[i][k] * B[k][j];
                check($sformatf("array_c%0d%0d", i, j), c, p);
            end
        end
        repeat (hold) begin
            @(posedge clk); #1;
            check("hold_status", status(), 4'b0010);
            check("hold_feeds", bus.a_out | bus.b_out, 0);
        end
        bus.res_ack = 1'b1;
        @(posedge clk); #1;
        bus.res_ack = 1'b0;
        check("ack_to_load", status(), 4'b0001);
        check("early_beat", extra_hs, 0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.res_ack  = 1'b0;
        @(posedge clk); #1;
        check("reset_status", status(), 4'b1000);
        check("reset_feeds", bus.a_out | bus.b_out, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset_release", status(), 4'b1001);

        for (int i = 0; i < N; i++) for (int k = 0; k < K; k++) A[i][k] = (i == k) ? 1 : 0;
        for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) B[k][j] = 10 * k + j;
        do_load(0);
        do_run(0, 2, -1);
`ifdef SYSTOLIC_FEEDER_PERF_EN
        check("perf_gapfree_identity", perf_cycles, 89);
`endif

        for (int i = 0; i < N; i++) for (int k = 0; k < K; k++) A[i][k] = i * 16 + k + 1;
        for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) B[k][j] = 1;
        do_load(0);
        do_run(1, 0, -1);
`ifdef SYSTOLIC_FEEDER_PERF_EN
        check("perf_gapfree_skew", perf_cycles, 89);
`endif

        rand_mats();
        do_load(40);
        do_run(0, 50, -1);

        rand_mats();
        do_load(20);
        do_run(0, 0, 7);

        rand_mats();
        do_load(20);
        do_run(0, 3, -1);

        rand_mats();
        do_load(60);
        do_run(0, 1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
